// File: rtl/wb_stage_mlane.sv
// N-lane writeback stage: MEM2->WB pipeline register, result select, conflict-gated
// write enables and a commit-trace FIFO. Define WB_STORE_TRACE_EN to add store fields to the trace.
module wb_stage_mlane #(
    parameter int LANES        = 2,
    parameter int TRACE_DEPTH  = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 WB_Flush,
    input  logic                 WB_Wr,
    input  logic                 WB_DisWr,
    input  logic [LANES-1:0]     m2_valid,
    input  logic [32*LANES-1:0]  m2_pc,
    input  logic [32*LANES-1:0]  m2_instr,
    input  logic [2*LANES-1:0]   m2_wbsel,
    input  logic [5*LANES-1:0]   m2_dst,
    input  logic [32*LANES-1:0]  m2_aluout,
    input  logic [32*LANES-1:0]  m2_outb,
    input  logic [32*LANES-1:0]  m2_dmout,
    input  logic [3*LANES-1:0]   m2_wrtype,
`ifdef WB_STORE_TRACE_EN
    input  logic [4*LANES-1:0]   m2_dcache_wen,
    input  logic [32*LANES-1:0]  m2_store_data,
`endif
    output logic [32*LANES-1:0]  wb_result,
    output logic [5*LANES-1:0]   wb_dst,
    output logic [32*LANES-1:0]  wb_pc,
    output logic [3*LANES-1:0]   wb_final_wr,
    output logic                 trace_valid,
    input  logic                 trace_ready,
`ifdef WB_STORE_TRACE_EN
    output logic [LANES*138-1:0] trace_data,
`else
    output logic [LANES*70-1:0]  trace_data,
`endif
    output logic                 wb_stall_req,
    output logic                 trace_overflow
);

    localparam int BASE_W = 1 + 32 + 5 + 32;
`ifdef WB_STORE_TRACE_EN
    localparam int LANE_W = BASE_W + 4 + 32 + 32;
`else
    localparam int LANE_W = BASE_W;
`endif
    localparam int ENTRY_W = LANES * LANE_W;
    localparam int AW      = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_V = (AW+1)'(TRACE_DEPTH);

    logic [LANES-1:0]    r_valid;
    logic [2*LANES-1:0]  r_wbsel;
    logic [32*LANES-1:0] r_aluout;
    logic [32*LANES-1:0] r_outb;
    logic [32*LANES-1:0] r_dmout;
    logic [3*LANES-1:0]  r_wrtype;
`ifdef WB_STORE_TRACE_EN
    logic [4*LANES-1:0]  r_wen;
    logic [32*LANES-1:0] r_store;
`endif
    logic                fresh;
    logic                push;

    // The instruction word is not part of the commit record.
    logic [32*LANES-1:0] unused_instr;
    assign unused_instr = m2_instr;

    // fresh marks a loaded bundle that has not yet been pushed to the trace.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid  <= '0;
            wb_pc    <= '0;
            r_wbsel  <= '0;
            wb_dst   <= '0;
            r_aluout <= '0;
            r_outb   <= '0;
            r_dmout  <= '0;
            r_wrtype <= '0;
`ifdef WB_STORE_TRACE_EN
            r_wen    <= '0;
            r_store  <= '0;
`endif
            fresh    <= 1'b0;
        end else if (WB_Flush) begin
            r_valid  <= '0;
            wb_pc    <= '0;
            r_wbsel  <= '0;
            wb_dst   <= '0;
            r_aluout <= '0;
            r_outb   <= '0;
            r_dmout  <= '0;
            r_wrtype <= '0;
`ifdef WB_STORE_TRACE_EN
            r_wen    <= '0;
            r_store  <= '0;
`endif
            fresh    <= 1'b0;
        end else if (WB_Wr) begin
            r_valid  <= m2_valid;
            wb_pc    <= m2_pc;
            r_wbsel  <= m2_wbsel;
            wb_dst   <= m2_dst;
            r_aluout <= m2_aluout;
            r_outb   <= m2_outb;
            r_dmout  <= m2_dmout;
            r_wrtype <= m2_wrtype;
`ifdef WB_STORE_TRACE_EN
            r_wen    <= m2_dcache_wen;
            r_store  <= m2_store_data;
`endif
            fresh    <= 1'b1;
        end else if (push) begin
            fresh    <= 1'b0;
        end
    end

    // Invalid lanes report a zero result so a flushed or reset stage reads all-zero.
    always_comb begin
        wb_result = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_valid[i]) begin
                case (r_wbsel[2*i +: 2])
                    2'd0:    wb_result[32*i +: 32] = wb_pc[32*i +: 32] + 32'd8;
                    2'd1:    wb_result[32*i +: 32] = r_aluout[32*i +: 32];
                    2'd2:    wb_result[32*i +: 32] = r_outb[32*i +: 32];
                    default: wb_result[32*i +: 32] = r_dmout[32*i +: 32];
                endcase
            end
        end
    end

    logic [3*LANES-1:0] base_wr;

    // A younger lane writing the same target masks every older lane's bit.
    always_comb begin
        base_wr = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_valid[i] && !WB_DisWr) begin
                base_wr[3*i+2] = r_wrtype[3*i+2];
                base_wr[3*i+1] = r_wrtype[3*i+1];
                base_wr[3*i]   = r_wrtype[3*i] && (wb_dst[5*i +: 5] != 5'd0);
            end
        end
        wb_final_wr = base_wr;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (base_wr[3*j] && (wb_dst[5*j +: 5] == wb_dst[5*i +: 5]))
                    wb_final_wr[3*i] = 1'b0;
                if (base_wr[3*j+1])
                    wb_final_wr[3*i+1] = 1'b0;
                if (base_wr[3*j+2])
                    wb_final_wr[3*i+2] = 1'b0;
            end
        end
    end

    logic [ENTRY_W-1:0] push_entry;

    always_comb begin
        push_entry = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef WB_STORE_TRACE_EN
            push_entry[LANE_W*i +: LANE_W] = {r_valid[i] & ~WB_DisWr, wb_pc[32*i +: 32],
                                              wb_dst[5*i +: 5], wb_result[32*i +: 32],
                                              r_wen[4*i +: 4] & {4{~WB_DisWr}},
                                              r_aluout[32*i +: 32],
                                              r_store[32*i +: 32] & {32{~WB_DisWr}}};
`else
            push_entry[LANE_W*i +: LANE_W] = {r_valid[i] & ~WB_DisWr, wb_pc[32*i +: 32],
                                              wb_dst[5*i +: 5], wb_result[32*i +: 32]};
`endif
        end
    end

    logic [ENTRY_W-1:0] mem [TRACE_DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [AW:0]        count;
    logic [AW:0]        free_slots;
    logic               full;
    logic               pop;
    logic               push_acc;

    assign push        = fresh && (|r_valid) && !WB_DisWr;
    assign trace_valid = (wr_ptr != rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop         = trace_valid && trace_ready;
    assign push_acc    = push && (!full || pop);
    assign count       = wr_ptr - rd_ptr;
    assign free_slots  = DEPTH_V - count;
    assign wb_stall_req = (32'(free_slots) <= 32'(AFULL_MARGIN));
    assign trace_data  = trace_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push_acc)
            mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            trace_overflow <= 1'b0;
        end else begin
            if (push_acc)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && full && !pop)
                trace_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_stage_mlane.sv
// Self-checking bench for wb_stage_mlane: directed scenarios plus randomized traffic
// checked against a queue-based commit-trace model.
module tb_wb_stage_mlane;

    localparam int LANES  = 2;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;
    localparam int LW     = 70;
    localparam int EW     = LANES * LW;

    logic                clk = 1'b0;
    logic                resetn;
    logic                WB_Flush, WB_Wr, WB_DisWr;
    logic [LANES-1:0]    m2_valid;
    logic [32*LANES-1:0] m2_pc, m2_instr, m2_aluout, m2_outb, m2_dmout;
    logic [2*LANES-1:0]  m2_wbsel;
    logic [5*LANES-1:0]  m2_dst;
    logic [3*LANES-1:0]  m2_wrtype;
    logic [32*LANES-1:0] wb_result, wb_pc;
    logic [5*LANES-1:0]  wb_dst;
    logic [3*LANES-1:0]  wb_final_wr;
    logic                trace_valid, trace_ready;
    logic [EW-1:0]       trace_data;
    logic                wb_stall_req, trace_overflow;

    always #5 clk = ~clk;

    wb_stage_mlane #(.LANES(LANES), .TRACE_DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
        .clk(clk), .resetn(resetn),
        .WB_Flush(WB_Flush), .WB_Wr(WB_Wr), .WB_DisWr(WB_DisWr),
        .m2_valid(m2_valid), .m2_pc(m2_pc), .m2_instr(m2_instr), .m2_wbsel(m2_wbsel),
        .m2_dst(m2_dst), .m2_aluout(m2_aluout), .m2_outb(m2_outb), .m2_dmout(m2_dmout),
        .m2_wrtype(m2_wrtype),
        .wb_result(wb_result), .wb_dst(wb_dst), .wb_pc(wb_pc), .wb_final_wr(wb_final_wr),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
        .wb_stall_req(wb_stall_req), .trace_overflow(trace_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the bundle currently held by the stage, whether it still owes
    // a trace record, the expected trace contents and the sticky overflow flag.
    logic        mb_valid [LANES];
    logic [31:0] mb_pc    [LANES];
    logic [1:0]  mb_sel   [LANES];
    logic [4:0]  mb_dst   [LANES];
    logic [31:0] mb_alu   [LANES];
    logic [31:0] mb_outb  [LANES];
    logic [31:0] mb_dm    [LANES];
    logic [2:0]  mb_wt    [LANES];
    bit          m_pending;
    bit          m_ovf;
    logic [EW-1:0] exp_q[$];

    task automatic model_clear_bundle();
        for (int l = 0; l < LANES; l++) begin
            mb_valid[l] = 1'b0; mb_pc[l] = '0; mb_sel[l] = '0; mb_dst[l] = '0;
            mb_alu[l] = '0; mb_outb[l] = '0; mb_dm[l] = '0; mb_wt[l] = '0;
        end
        m_pending = 1'b0;
    endtask

    task automatic model_reset();
        model_clear_bundle();
        exp_q.delete();
        m_ovf = 1'b0;
    endtask

    function automatic logic [31:0] ref_result(int l);
        if (!mb_valid[l]) return 32'd0;
        case (mb_sel[l])
            2'd0:    return mb_pc[l] + 32'd8;
            2'd1:    return mb_alu[l];
            2'd2:    return mb_outb[l];
            default: return mb_dm[l];
        endcase
    endfunction

    function automatic logic [3*LANES-1:0] ref_wr(logic dis);
        logic [3*LANES-1:0] r = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int b = 0; b < 3; b++) begin
                logic w;
                w = mb_valid[l] && !dis && mb_wt[l][b];
                if (b == 0 && mb_dst[l] == 5'd0) w = 1'b0;
                for (int k = l + 1; k < LANES; k++)
                    if (mb_valid[k] && mb_wt[k][b] && (b != 0 || mb_dst[k] == mb_dst[l]))
                        w = 1'b0;
                r[3*l+b] = w;
            end
        end
        return r;
    endfunction

    function automatic logic [EW-1:0] ref_entry(logic dis);
        logic [EW-1:0] e = '0;
        for (int l = 0; l < LANES; l++)
            e[LW*l +: LW] = {mb_valid[l] & ~dis, mb_pc[l], mb_dst[l], ref_result(l)};
        return e;
    endfunction

    function automatic bit any_valid();
        for (int l = 0; l < LANES; l++) if (mb_valid[l]) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        bit do_push, do_pop;
        logic [EW-1:0] e, dropped;
        do_push = m_pending && any_valid() && !WB_DisWr;
        do_pop  = (exp_q.size() > 0) && trace_ready;
        e = ref_entry(WB_DisWr);
        if (do_pop) dropped = exp_q.pop_front();
        if (do_push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(e);
            else m_ovf = 1'b1;
        end
        if (WB_Flush) begin
            model_clear_bundle();
        end else if (WB_Wr) begin
            for (int l = 0; l < LANES; l++) begin
                mb_valid[l] = m2_valid[l];
                mb_pc[l]    = m2_pc[32*l +: 32];
                mb_sel[l]   = m2_wbsel[2*l +: 2];
                mb_dst[l]   = m2_dst[5*l +: 5];
                mb_alu[l]   = m2_aluout[32*l +: 32];
                mb_outb[l]  = m2_outb[32*l +: 32];
                mb_dm[l]    = m2_dmout[32*l +: 32];
                mb_wt[l]    = m2_wrtype[3*l +: 3];
            end
            m_pending = 1'b1;
        end else if (do_push) begin
            m_pending = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input logic v, input logic [31:0] pc, input logic [1:0] sel,
                            input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] ob,
                            input logic [31:0] dm, input logic [2:0] wt);
        m2_valid[l]           = v;
        m2_pc[32*l +: 32]     = pc;
        m2_wbsel[2*l +: 2]    = sel;
        m2_dst[5*l +: 5]      = dst;
        m2_aluout[32*l +: 32] = alu;
        m2_outb[32*l +: 32]   = ob;
        m2_dmout[32*l +: 32]  = dm;
        m2_wrtype[3*l +: 3]   = wt;
    endtask

    task automatic set_idle();
        WB_Flush = 1'b0; WB_Wr = 1'b0; WB_DisWr = 1'b0;
        m2_valid = '0; m2_pc = '0; m2_instr = '0; m2_wbsel = '0; m2_dst = '0;
        m2_aluout = '0; m2_outb = '0; m2_dmout = '0; m2_wrtype = '0;
    endtask

    task automatic drain_and_flush();
        set_idle();
        trace_ready = 1'b1;
        repeat (DEPTH + 3) tick();
        WB_Flush = 1'b1;
        tick();
        WB_Flush = 1'b0;
    endtask

    task automatic load_and_push(input int k);
        set_lane(0, 1'b1, 32'(k * 16),     2'd1, 5'd3, $urandom, $urandom, $urandom, 3'b001);
        set_lane(1, 1'b1, 32'(k * 16 + 4), 2'd1, 5'd4, $urandom, $urandom, $urandom, 3'b001);
        WB_Wr = 1'b1;
        tick();
        WB_Wr = 1'b0;
        tick();
    endtask

    task automatic apply_reset();
        set_idle();
        trace_ready = 1'b0;
        resetn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        trace_ready = 1'b0;
        resetn = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (wb_result !== '0 || wb_pc !== '0 || wb_dst !== '0 || wb_final_wr !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_wb: got result=%h pc=%h dst=%h wr=%h, expected all 0", wb_result, wb_pc, wb_dst, wb_final_wr);
        end
        n_checks++;
        if (trace_valid !== 1'b0 || trace_overflow !== 1'b0 || trace_data !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_trace: got valid=%b ovf=%b, expected 0 0", trace_valid, trace_overflow);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_select();
        drain_and_flush();
        set_lane(0, 1'b1, 32'h1FC0_0000, 2'd0, 5'd1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 3'b000);
        set_lane(1, 1'b1, 32'h1FC0_0004, 2'd3, 5'd2, 32'h4444_4444, 32'h5555_5555, 32'hDEAD_BEEF, 3'b000);
        WB_Wr = 1'b1;
        tick();
        WB_Wr = 1'b0;
        n_checks++;
        if (wb_result !== 64'hDEAD_BEEF_1FC0_0008) begin
            n_fail++;
            $display("[TB] FAIL select_result: got %h, expected %h", wb_result, 64'hDEAD_BEEF_1FC0_0008);
        end
        n_checks++;
        if (wb_pc !== 64'h1FC0_0004_1FC0_0000 || wb_dst !== 10'b00010_00001) begin
            n_fail++;
            $display("[TB] FAIL select_regs: got pc=%h dst=%h", wb_pc, wb_dst);
        end
        set_lane(0, 1'b1, 32'hFFFF_FFFC, 2'd0, 5'd1, 0, 0, 0, 3'b000);
        set_lane(1, 1'b1, 32'h0, 2'd2, 5'd2, 0, 32'hCAFE_F00D, 0, 3'b000);
        WB_Wr = 1'b1;
        tick();
        WB_Wr = 1'b0;
        n_checks++;
        if (wb_result !== 64'hCAFE_F00D_0000_0004) begin
            n_fail++;
            $display("[TB] FAIL select_wrap: got %h, expected %h", wb_result, 64'hCAFE_F00D_0000_0004);
        end
    endtask

    task automatic test_conflict();
        logic [4:0] d0 [5];
        logic [4:0] d1 [5];
        logic [2:0] wt [5];
        logic       v1 [5];
        logic [5:0] exp_wr [5];
        d0 = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd7};
        d1 = '{5'd5, 5'd0, 5'd6, 5'd5, 5'd7};
        wt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b110};
        v1 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_wr = '{6'b001_000, 6'b000_000, 6'b001_001, 6'b000_001, 6'b110_000};
        drain_and_flush();
        for (int t = 0; t < 5; t++) begin
            set_lane(0, 1'b1, 32'h100, 2'd1, d0[t], $urandom, 0, 0, wt[t]);
            set_lane(1, v1[t], 32'h104, 2'd1, d1[t], $urandom, 0, 0, wt[t]);
            WB_Wr = 1'b1;
            tick();
            WB_Wr = 1'b0;
            n_checks++;
            if (wb_final_wr !== exp_wr[t]) begin
                n_fail++;
                $display("[TB] FAIL conflict_%0d: got %b, expected %b", t, wb_final_wr, exp_wr[t]);
            end
        end
    endtask

    task automatic test_diswr();
        drain_and_flush();
        trace_ready = 1'b0;
        set_lane(0, 1'b1, 32'h200, 2'd1, 5'd7, 32'hA0A0_A0A0, 0, 0, 3'b001);
        set_lane(1, 1'b1, 32'h204, 2'd1, 5'd9, 32'hB0B0_B0B0, 0, 0, 3'b001);
        WB_Wr = 1'b1;
        tick();
        WB_Wr = 1'b0;
        WB_DisWr = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (wb_final_wr !== '0) begin
                n_fail++;
                $display("[TB] FAIL diswr_gate_%0d: got %b, expected 0", c, wb_final_wr);
            end
            tick();
            n_checks++;
            if (trace_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL diswr_nopush_%0d: got trace_valid=%b, expected 0", c, trace_valid);
            end
        end
        WB_DisWr = 1'b0;
        #1;
        n_checks++;
        if (wb_final_wr !== 6'b001_001) begin
            n_fail++;
            $display("[TB] FAIL diswr_release: got %b, expected %b", wb_final_wr, 6'b001_001);
        end
        repeat (3) tick();
        n_checks++;
        if (trace_valid !== 1'b1 || exp_q.size() == 0 || trace_data !== exp_q[0]) begin
            n_fail++;
            $display("[TB] FAIL diswr_push: got valid=%b data=%h", trace_valid, trace_data);
        end
        trace_ready = 1'b1;
        tick();
        n_checks++;
        if (trace_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL diswr_single: got trace_valid=%b after one pop, expected 0", trace_valid);
        end
    endtask

    task automatic drain_count(input string name);
        int pops = 0;
        trace_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (trace_valid !== 1'b1) break;
            n_checks++;
            if (exp_q.size() == 0 || trace_data !== exp_q[0]) begin
                n_fail++;
                $display("[TB] FAIL %s_order_%0d: got %h", name, pops, trace_data);
            end
            pops++;
            tick();
        end
        n_checks++;
        if (pops != DEPTH) begin
            n_fail++;
            $display("[TB] FAIL %s_count: got %0d entries, expected %0d", name, pops, DEPTH);
        end
        trace_ready = 1'b0;
    endtask

    task automatic test_fifo_full();
        apply_reset();
        for (int k = 1; k <= DEPTH; k++) begin
            load_and_push(k);
            if (k == 5 || k == 6) begin
                n_checks++;
                if (wb_stall_req !== (k == 6)) begin
                    n_fail++;
                    $display("[TB] FAIL stall_at_%0d: got %b, expected %b", k, wb_stall_req, k == 6);
                end
            end
        end
        n_checks++;
        if (trace_overflow !== 1'b0 || wb_stall_req !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL full_state: got ovf=%b stall=%b, expected 0 1", trace_overflow, wb_stall_req);
        end
        set_lane(0, 1'b1, 32'h900, 2'd1, 5'd3, $urandom, 0, 0, 3'b001);
        set_lane(1, 1'b1, 32'h904, 2'd1, 5'd4, $urandom, 0, 0, 3'b001);
        WB_Wr = 1'b1;
        tick();
        WB_Wr = 1'b0;
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        n_checks++;
        if (trace_overflow !== 1'b0 || wb_stall_req !== 1'b1 || trace_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL full_push_pop: got ovf=%b stall=%b valid=%b, expected 0 1 1", trace_overflow, wb_stall_req, trace_valid);
        end
        drain_count("pushpop");
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int k = 1; k <= DEPTH + 1; k++) load_and_push(k + 32);
        n_checks++;
        if (trace_overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL overflow_flag: got %b, expected 1", trace_overflow);
        end
        drain_count("overflow");
        n_checks++;
        if (trace_overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL overflow_sticky: got %b, expected 1", trace_overflow);
        end
    endtask

    task automatic test_reset_mid();
        trace_ready = 1'b0;
        for (int k = 1; k <= 3; k++) load_and_push(k + 64);
        n_checks++;
        if (trace_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midreset_queued: got trace_valid=%b, expected 1", trace_valid);
        end
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (trace_valid !== 1'b0 || trace_data !== '0 || trace_overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_trace: got valid=%b ovf=%b data=%h, expected 0", trace_valid, trace_overflow, trace_data);
        end
        n_checks++;
        if (wb_result !== '0 || wb_pc !== '0 || wb_dst !== '0 || wb_final_wr !== '0) begin
            n_fail++;
            $display("[TB] FAIL midreset_wb: got result=%h pc=%h dst=%h wr=%h, expected 0", wb_result, wb_pc, wb_dst, wb_final_wr);
        end
        set_idle();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            WB_Wr       = ($urandom_range(1) == 1);
            WB_Flush    = ($urandom_range(7) == 0);
            WB_DisWr    = ($urandom_range(3) == 0);
            trace_ready = ($urandom_range(2) == 0);
            for (int l = 0; l < LANES; l++)
                set_lane(l, $urandom_range(3) != 0, $urandom, 2'($urandom_range(3)),
                         5'($urandom_range(3)), $urandom, $urandom, $urandom, 3'($urandom_range(7)));
            m2_instr = {$urandom, $urandom};
            #1;
            for (int l = 0; l < LANES; l++) begin
                n_checks++;
                if (wb_result[32*l +: 32] !== ref_result(l)) begin
                    n_fail++;
                    $display("[TB] FAIL rand_result_l%0d @%0d: got %h, expected %h", l, c, wb_result[32*l +: 32], ref_result(l));
                end
                n_checks++;
                if (wb_pc[32*l +: 32] !== mb_pc[l] || wb_dst[5*l +: 5] !== mb_dst[l]) begin
                    n_fail++;
                    $display("[TB] FAIL rand_regs_l%0d @%0d: got pc=%h dst=%0d, expected pc=%h dst=%0d", l, c, wb_pc[32*l +: 32], wb_dst[5*l +: 5], mb_pc[l], mb_dst[l]);
                end
            end
            n_checks++;
            if (wb_final_wr !== ref_wr(WB_DisWr)) begin
                n_fail++;
                $display("[TB] FAIL rand_wr @%0d: got %b, expected %b", c, wb_final_wr, ref_wr(WB_DisWr));
            end
            n_checks++;
            if (trace_valid !== (exp_q.size() > 0) || trace_data !== ((exp_q.size() > 0) ? exp_q[0] : '0)) begin
                n_fail++;
                $display("[TB] FAIL rand_trace @%0d: got valid=%b data=%h, expected valid=%b", c, trace_valid, trace_data, exp_q.size() > 0);
            end
            n_checks++;
            if (wb_stall_req !== ((DEPTH - exp_q.size()) <= MARGIN) || trace_overflow !== m_ovf) begin
                n_fail++;
                $display("[TB] FAIL rand_status @%0d: got stall=%b ovf=%b, expected stall=%b ovf=%b", c, wb_stall_req, trace_overflow, (DEPTH - exp_q.size()) <= MARGIN, m_ovf);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_conflict();
        test_diswr();
        test_fifo_full();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
